// File: rtl/mcu_pkg.sv
// mcu_pkg: states, opcodes, control encodings and dispatch for multicycle_ctrl (MCU_JAL_EN adds JAL)
package mcu_pkg;
   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_R, S_WB_I, S_MEM_ADDR,
      S_MEM_RD, S_MEM_WR, S_WB_MEM, S_BRANCH, S_JUMP, S_FAULT
   } state_t;
   localparam logic [5:0] OP_RR = 6'b000000, OP_REGIMM = 6'b000001, OP_J = 6'b000010, OP_JAL = 6'b000011;
   localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_BLEZ = 6'b000110, OP_BGTZ = 6'b000111;
   localparam logic [5:0] OP_ADDI = 6'b001000, OP_ADDIU = 6'b001001, OP_SLTI = 6'b001010, OP_SLTIU = 6'b001011;
   localparam logic [5:0] OP_ANDI = 6'b001100, OP_ORI = 6'b001101, OP_XORI = 6'b001110, OP_LUI = 6'b001111;
   localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011;
   localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_RTYPE = 4'd2, ALU_AND = 4'd3, ALU_OR = 4'd4;
   localparam logic [3:0] ALU_XOR = 4'd5, ALU_SLT = 4'd6, ALU_SLTU = 4'd7, ALU_ADDU = 4'd8;
   localparam logic [1:0] SRCB_RT = 2'd0, SRCB_FOUR = 2'd1, SRCB_IMM = 2'd2, SRCB_IMM_SH = 2'd3;
   localparam logic [1:0] PC_ALU = 2'd0, PC_ALUOUT = 2'd1, PC_JUMP = 2'd2;
   typedef struct packed {
      logic       pc_wr;
      logic       ir_wr;
      logic       iord;
      logic       mem_rd;
      logic       mem_wr;
      logic       reg_wr;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [3:0] alu_op;
      logic [1:0] pc_src;
      logic       branch;
      logic       sigext_high;
      logic       link;
      logic       fault;
   } ctrl_t;
   // S_FETCH doubles as the "undecodable" marker
   function automatic state_t dispatch(input logic [5:0] op);
      case (op)
         OP_RR: return S_EXEC_R;
         OP_LW, OP_SW: return S_MEM_ADDR;
         OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_REGIMM: return S_BRANCH;
         OP_J: return S_JUMP;
`ifdef MCU_JAL_EN
         OP_JAL: return S_JUMP;
`endif
         OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_SLTIU, OP_LUI: return S_EXEC_I;
         default: return S_FETCH;
      endcase
   endfunction
   function automatic logic [3:0] alu_imm(input logic [5:0] op);
      case (op)
         OP_ADDIU: return ALU_ADDU;
         OP_ANDI: return ALU_AND;
         OP_ORI: return ALU_OR;
         OP_XORI: return ALU_XOR;
         OP_SLTI: return ALU_SLT;
         OP_SLTIU: return ALU_SLTU;
         default: return ALU_ADD;
      endcase
   endfunction
endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: opcode/memory handshake and datapath control bundle of multicycle_ctrl
interface multicycle_ctrl_if #(parameter int ALUOP_W = 4);
   logic [5:0]         op_code;
   logic               mem_ready;
   logic               pc_wr, ir_wr, iord, mem_rd, mem_wr, reg_wr, reg_dst, mem_to_reg, alu_src_a;
   logic [1:0]         alu_src_b;
   logic [ALUOP_W-1:0] alu_op;
   logic [1:0]         pc_src;
   logic               branch, sigext_high, link, illegal, fault;
   logic [3:0]         state;
   modport master (
      input  op_code, mem_ready,
      output pc_wr, ir_wr, iord, mem_rd, mem_wr, reg_wr, reg_dst, mem_to_reg, alu_src_a,
             alu_src_b, alu_op, pc_src, branch, sigext_high, link, illegal, fault, state
   );
   modport slave (
      output op_code, mem_ready,
      input  pc_wr, ir_wr, iord, mem_rd, mem_wr, reg_wr, reg_dst, mem_to_reg, alu_src_a,
             alu_src_b, alu_op, pc_src, branch, sigext_high, link, illegal, fault, state
   );
endinterface

// File: rtl/mcu_out_decode.sv
// mcu_out_decode: combinational control word from state, latched opcode and mem_ready (MCU_JAL_EN adds link)
module mcu_out_decode
   import mcu_pkg::*;
(
   input  state_t     state,
   input  logic [5:0] op,
   input  logic       mem_ready,
   output ctrl_t      ctrl
);
   always_comb begin
      ctrl = '0;
      case (state)
         S_FETCH: begin
            ctrl.mem_rd = 1'b1;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.ir_wr = mem_ready;
            ctrl.pc_wr = mem_ready;
         end
         S_DECODE: ctrl.alu_src_b = SRCB_IMM_SH;
         S_EXEC_R: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_op = ALU_RTYPE;
         end
         S_EXEC_I: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op = alu_imm(op);
            ctrl.sigext_high = op == OP_LUI;
         end
         S_WB_R: begin
            ctrl.reg_wr = 1'b1;
            ctrl.reg_dst = 1'b1;
         end
         S_WB_I: begin
            ctrl.reg_wr = 1'b1;
            ctrl.alu_op = alu_imm(op);
            ctrl.sigext_high = op == OP_LUI;
         end
         S_MEM_ADDR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
         end
         S_MEM_RD: begin
            ctrl.mem_rd = 1'b1;
            ctrl.iord = 1'b1;
         end
         S_MEM_WR: begin
            ctrl.mem_wr = 1'b1;
            ctrl.iord = 1'b1;
         end
         S_WB_MEM: begin
            ctrl.reg_wr = 1'b1;
            ctrl.mem_to_reg = 1'b1;
         end
         S_BRANCH: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_op = ALU_SUB;
            ctrl.branch = 1'b1;
            ctrl.pc_src = PC_ALUOUT;
         end
         S_JUMP: begin
            ctrl.pc_wr = 1'b1;
            ctrl.pc_src = PC_JUMP;
`ifdef MCU_JAL_EN
            ctrl.reg_wr = op == OP_JAL;
            ctrl.link = op == OP_JAL;
`endif
         end
         S_FAULT: ctrl.fault = 1'b1;
         default: ;
      endcase
   end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle MIPS main control FSM with bounded memory wait (MCU_JAL_EN enables JAL)
module multicycle_ctrl
   import mcu_pkg::*;
#(
   parameter int ALUOP_W     = 4,
   parameter int MEM_TIMEOUT = 255
) (
   input logic clk,
   input logic rst_n,
   multicycle_ctrl_if.master bus
);
   state_t      state_q, state_d;
   logic [5:0]  op_q;
   logic [15:0] cnt_q;
   logic        illegal_q, mem_st, timeout;
   ctrl_t       ctrl, ctrl_g;
   assign mem_st = state_q inside {S_FETCH, S_MEM_RD, S_MEM_WR};
   // the cycle that would push the count to the limit without ready is the fault cycle
   assign timeout = mem_st && !bus.mem_ready && cnt_q == 16'(MEM_TIMEOUT - 1);
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         cnt_q <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= (mem_st && !bus.mem_ready) ? cnt_q + 16'd1 : '0;
         if (state_q == S_DECODE) op_q <= bus.op_code;
         if (state_q == S_DECODE && dispatch(bus.op_code) == S_FETCH) illegal_q <= 1'b1;
      end
   end
   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH: state_d = bus.mem_ready ? S_DECODE : timeout ? S_FAULT : S_FETCH;
         S_DECODE: state_d = dispatch(bus.op_code);
         S_EXEC_R: state_d = S_WB_R;
         S_EXEC_I: state_d = S_WB_I;
         S_MEM_ADDR: state_d = op_q == OP_LW ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD: state_d = bus.mem_ready ? S_WB_MEM : timeout ? S_FAULT : S_MEM_RD;
         S_MEM_WR: state_d = bus.mem_ready ? S_FETCH : timeout ? S_FAULT : S_MEM_WR;
         S_FAULT: state_d = S_FAULT;
         default: state_d = S_FETCH;
      endcase
   end
   mcu_out_decode u_dec (
      .state(state_q),
      .op(op_q),
      .mem_ready(bus.mem_ready),
      .ctrl(ctrl)
   );
   assign ctrl_g = rst_n ? ctrl : '0;
   assign bus.pc_wr = ctrl_g.pc_wr;
   assign bus.ir_wr = ctrl_g.ir_wr;
   assign bus.iord = ctrl_g.iord;
   assign bus.mem_rd = ctrl_g.mem_rd;
   assign bus.mem_wr = ctrl_g.mem_wr;
   assign bus.reg_wr = ctrl_g.reg_wr;
   assign bus.reg_dst = ctrl_g.reg_dst;
   assign bus.mem_to_reg = ctrl_g.mem_to_reg;
   assign bus.alu_src_a = ctrl_g.alu_src_a;
   assign bus.alu_src_b = ctrl_g.alu_src_b;
   assign bus.alu_op = ALUOP_W'(ctrl_g.alu_op);
   assign bus.pc_src = ctrl_g.pc_src;
   assign bus.branch = ctrl_g.branch;
   assign bus.sigext_high = ctrl_g.sigext_high;
   assign bus.link = ctrl_g.link;
   assign bus.fault = ctrl_g.fault;
   assign bus.illegal = rst_n & illegal_q;
   assign bus.state = state_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed per-cycle vectors scored against the state and full control word
module tb_multicycle_ctrl;
   import mcu_pkg::*;
   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;
   multicycle_ctrl_if #(.ALUOP_W(4)) bus ();
   multicycle_ctrl #(.ALUOP_W(4), .MEM_TIMEOUT(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));
   typedef struct {
      string       tag;
      logic [3:0]  st;
      logic [21:0] ctl;
   } exp_t;
   exp_t sb[$];
   int tests = 0, fails = 0;
   localparam logic [5:0] ADD = 6'b000000, LW = 6'b100011, SW = 6'b101011, LUI = 6'b001111;
   localparam logic [5:0] ORI = 6'b001101, BEQ = 6'b000100, JJ = 6'b000010, JAL = 6'b000011, BAD = 6'b111111;
   // pw iw io mr mw rw rd m2r sa sb op ps br sh lk il ft
   localparam logic [21:0] FW    = 22'b0_0_0_1_0_0_0_0_0_01_0000_00_0_0_0_0_0;
   localparam logic [21:0] FR    = 22'b1_1_0_1_0_0_0_0_0_01_0000_00_0_0_0_0_0;
   localparam logic [21:0] DEC   = 22'b0_0_0_0_0_0_0_0_0_11_0000_00_0_0_0_0_0;
   localparam logic [21:0] EXR   = 22'b0_0_0_0_0_0_0_0_1_00_0010_00_0_0_0_0_0;
   localparam logic [21:0] WBR   = 22'b0_0_0_0_0_1_1_0_0_00_0000_00_0_0_0_0_0;
   localparam logic [21:0] MA    = 22'b0_0_0_0_0_0_0_0_1_10_0000_00_0_0_0_0_0;
   localparam logic [21:0] MRD   = 22'b0_0_1_1_0_0_0_0_0_00_0000_00_0_0_0_0_0;
   localparam logic [21:0] MWR   = 22'b0_0_1_0_1_0_0_0_0_00_0000_00_0_0_0_0_0;
   localparam logic [21:0] WBM   = 22'b0_0_0_0_0_1_0_1_0_00_0000_00_0_0_0_0_0;
   localparam logic [21:0] EXLUI = 22'b0_0_0_0_0_0_0_0_1_10_0000_00_0_1_0_0_0;
   localparam logic [21:0] WBLUI = 22'b0_0_0_0_0_1_0_0_0_00_0000_00_0_1_0_0_0;
   localparam logic [21:0] EXORI = 22'b0_0_0_0_0_0_0_0_1_10_0100_00_0_0_0_0_0;
   localparam logic [21:0] WBORI = 22'b0_0_0_0_0_1_0_0_0_00_0100_00_0_0_0_0_0;
   localparam logic [21:0] BR    = 22'b0_0_0_0_0_0_0_0_1_00_0001_01_1_0_0_0_0;
   localparam logic [21:0] JMP   = 22'b1_0_0_0_0_0_0_0_0_00_0000_10_0_0_0_0_0;
   localparam logic [21:0] JLNK  = 22'b1_0_0_0_0_1_0_0_0_00_0000_10_0_0_1_0_0;
   localparam logic [21:0] FLT   = 22'd1;
   localparam logic [21:0] IL    = 22'd2;
   function automatic logic [21:0] obs();
      return {bus.pc_wr, bus.ir_wr, bus.iord, bus.mem_rd, bus.mem_wr, bus.reg_wr, bus.reg_dst,
              bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_src, bus.branch,
              bus.sigext_high, bus.link, bus.illegal, bus.fault};
   endfunction
   task automatic cyc(input logic rn, input logic [5:0] op, input logic rdy, input string tag,
                      input state_t st, input logic [21:0] ctl);
      @(posedge clk);
      #1;
      rst_n = rn;
      bus.op_code = op;
      bus.mem_ready = rdy;
      sb.push_back('{tag, st, ctl});
   endtask
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            tests++;
            if (bus.state !== e.st) begin
               fails++;
               $display("FAIL %s state got %0d want %0d", e.tag, bus.state, e.st);
            end
            tests++;
            if (obs() !== e.ctl) begin
               fails++;
               $display("FAIL %s ctl got %b want %b", e.tag, obs(), e.ctl);
            end
         end
      end
   end
   initial begin
      logic [21:0] il;
      bus.op_code = ADD;
      bus.mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      cyc(0, ADD, 1, "rst", S_FETCH, '0);
      cyc(1, ADD, 1, "add_f", S_FETCH, FR);
      cyc(1, ADD, 1, "add_d", S_DECODE, DEC);
      cyc(1, ADD, 1, "add_x", S_EXEC_R, EXR);
      cyc(1, ADD, 1, "add_wb", S_WB_R, WBR);
      for (int i = 0; i < 3; i++) cyc(1, LW, 0, "lw_fwait", S_FETCH, FW);
      cyc(1, LW, 1, "lw_f", S_FETCH, FR);
      cyc(1, LW, 0, "lw_d", S_DECODE, DEC);
      cyc(1, SW, 0, "lw_ma", S_MEM_ADDR, MA);
      for (int i = 0; i < 2; i++) cyc(1, SW, 0, "lw_rwait", S_MEM_RD, MRD);
      cyc(1, SW, 1, "lw_r", S_MEM_RD, MRD);
      cyc(1, SW, 0, "lw_wb", S_WB_MEM, WBM);
      cyc(1, LUI, 1, "lui_f", S_FETCH, FR);
      cyc(1, LUI, 1, "lui_d", S_DECODE, DEC);
      cyc(1, ORI, 1, "lui_x", S_EXEC_I, EXLUI);
      cyc(1, ORI, 1, "lui_wb", S_WB_I, WBLUI);
      cyc(1, ORI, 1, "ori_f", S_FETCH, FR);
      cyc(1, ORI, 1, "ori_d", S_DECODE, DEC);
      cyc(1, LUI, 1, "ori_x", S_EXEC_I, EXORI);
      cyc(1, LUI, 1, "ori_wb", S_WB_I, WBORI);
      cyc(1, BEQ, 1, "beq_f", S_FETCH, FR);
      cyc(1, BEQ, 1, "beq_d", S_DECODE, DEC);
      cyc(1, BEQ, 1, "beq_x", S_BRANCH, BR);
      cyc(1, JJ, 1, "j_f", S_FETCH, FR);
      cyc(1, JJ, 1, "j_d", S_DECODE, DEC);
      cyc(1, JJ, 1, "j_x", S_JUMP, JMP);
      cyc(1, SW, 1, "sw_f", S_FETCH, FR);
      cyc(1, SW, 1, "sw_d", S_DECODE, DEC);
      cyc(1, SW, 0, "sw_ma", S_MEM_ADDR, MA);
      cyc(1, SW, 1, "sw_w", S_MEM_WR, MWR);
      cyc(1, JAL, 1, "jal_f", S_FETCH, FR);
      cyc(1, JAL, 1, "jal_d", S_DECODE, DEC);
`ifdef MCU_JAL_EN
      cyc(1, JAL, 1, "jal_x", S_JUMP, JLNK);
      il = '0;
`else
      il = IL;
`endif
      cyc(1, BAD, 1, "ill_f", S_FETCH, FR | il);
      cyc(1, BAD, 1, "ill_d", S_DECODE, DEC | il);
      cyc(1, ADD, 0, "ill_sticky", S_FETCH, FW | IL);
      cyc(0, ADD, 0, "ill_rst", S_FETCH, '0);
      cyc(1, ADD, 1, "ill_clr", S_FETCH, FR);
      cyc(1, SW, 0, "to_d", S_DECODE, DEC);
      cyc(1, SW, 0, "to_ma", S_MEM_ADDR, MA);
      for (int i = 0; i < 3; i++) cyc(1, SW, 0, "to_wait", S_MEM_WR, MWR);
      cyc(1, SW, 1, "to_last_rdy", S_MEM_WR, MWR);
      cyc(1, SW, 1, "to_f", S_FETCH, FR);
      cyc(1, SW, 1, "to2_d", S_DECODE, DEC);
      cyc(1, SW, 0, "to2_ma", S_MEM_ADDR, MA);
      for (int i = 0; i < 4; i++) cyc(1, SW, 0, "to2_wait", S_MEM_WR, MWR);
      cyc(1, SW, 1, "fault", S_FAULT, FLT);
      cyc(1, SW, 1, "fault_hold", S_FAULT, FLT);
      cyc(0, SW, 1, "fault_rst", S_FAULT, '0);
      cyc(1, ADD, 1, "fault_clr", S_FETCH, FR);
      repeat (3) @(posedge clk);
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL drain left %0d want 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle main control unit for the MIPS datapath. It replaces the single-cycle opcode decoder with a registered state machine that sequences each instruction through fetch, decode, execute, memory and write-back. It emits per-cycle datapath control and handshakes with instruction/data memory through a ready signal, with a bounded wait. It sits between the instruction register (`op_code`) and the shared memory port, ALU control unit, register file and PC logic.

## Interface
- `ALUOP_W`, default 4: width of `alu_op`; matches the ALU control unit input.
- `MEM_TIMEOUT`, default 255: maximum wait cycles for `mem_ready` before a fault; legal range 1..65535.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `op_code` in 6: IR[31:26]; sampled only in DECODE.
- `mem_ready` in 1: memory completed the current access this cycle.
- `pc_wr` out 1: PC load enable.
- `ir_wr` out 1: IR load enable.
- `iord` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `mem_rd` out 1: memory read request.
- `mem_wr` out 1: memory write request.
- `reg_wr` out 1: register file write enable.
- `reg_dst` out 1: destination select; 1 = rd, 0 = rt.
- `mem_to_reg` out 1: write-back source; 1 = MDR.
- `alu_src_a` out 1: ALU A select; 0 = PC, 1 = rs.
- `alu_src_b` out 2: ALU B select; 0 = rt, 1 = 4, 2 = ext imm, 3 = ext imm<<2.
- `alu_op` out `ALUOP_W`: ALU operation class.
- `pc_src` out 2: PC source; 0 = ALU result, 1 = ALUOut (branch target), 2 = jump target.
- `branch` out 1: PC write qualified by branch condition.
- `sigext_high` out 1: immediate placed in upper half (LUI).
- `link` out 1: write PC+4 into $31 (see Configuration).
- `illegal` out 1: sticky; set on an undecodable opcode.
- `fault` out 1: set in FAULT.
- `state` out 4: current state, for debug.

## Operation
- Opcode is latched into an internal register in DECODE. Later IR changes do not affect the instruction in flight.
- FETCH: `mem_rd`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=1, ADD.
  - Waits for `mem_ready`.
  - On ready: `ir_wr`=1 and `pc_wr`=1 (`pc_src`=0) in the same cycle, then go to DECODE.
- DECODE: `alu_src_a`=0, `alu_src_b`=3, ADD (branch target precompute). Dispatch on opcode:
  - RR → EXEC_R.
  - LW/SW → MEM_ADDR.
  - BEQ/BNE/BLEZ/BGTZ/REGIMM → BRANCH.
  - J → JUMP.
  - ADDI/ADDIU/ANDI/ORI/XORI/SLTI/SLTIU/LUI → EXEC_I.
  - Other → set `illegal`, go to FETCH.
- EXEC_R: A=rs, B=rt, `alu_op`=R-class → WB_R.
- EXEC_I: A=rs, B=imm; `alu_op` per opcode (ADD, ADDU, AND, OR, XOR, SLT, SLTU; LUI uses ADD with `sigext_high`=1) → WB_I.
- WB_R: `reg_wr`=1, `reg_dst`=1 → FETCH.
- WB_I: `reg_wr`=1, `reg_dst`=0 → FETCH. `sigext_high` and `alu_op` are held from EXEC_I.
- MEM_ADDR: A=rs, B=imm, ADD → MEM_RD (LW) or MEM_WR (SW).
- MEM_RD: `mem_rd`=1, `iord`=1; on ready → WB_MEM.
- MEM_WR: `mem_wr`=1, `iord`=1; on ready → FETCH.
- WB_MEM: `reg_wr`=1, `mem_to_reg`=1, `reg_dst`=0 → FETCH.
- BRANCH: A=rs, B=rt, SUB, `branch`=1, `pc_src`=1 → FETCH.
- JUMP: `pc_wr`=1, `pc_src`=2 → FETCH.
- FAULT: all control outputs 0, `fault`=1. Terminal until reset.
- Wait counter (16 bit):
  - Cleared on entry to any memory state and on each `mem_ready`.
  - Increments each cycle a request is pending without ready.
  - When it reaches `MEM_TIMEOUT` with `mem_ready` still low → FAULT. Ready arriving in the same cycle as the limit wins.
- Outputs not listed for a state are 0.

## Timing
- State register and latched opcode update on the rising edge. Control outputs are combinational from state; `ir_wr`/`pc_wr` in FETCH are also gated by `mem_ready`.
- Reset: while `rst_n`=0 at an edge, state ← FETCH, wait counter ← 0, `illegal` ← 0.
  - All control outputs are forced 0 while `rst_n` is low. `state` reads FETCH after the reset edge.
  - Reset mid-instruction abandons it with no write issued.
- Cycles per instruction with zero-wait memory (ready in the first request cycle):
  - R/I-type: 4.
  - LW: 5.
  - SW: 4.
  - Branch and J: 3.
- Each memory wait cycle adds 1.
- Request signals stay stable until the cycle where `mem_ready`=1.

## Configuration
- `MCU_JAL_EN` defined: opcode 000011 (JAL) dispatches to JUMP. JUMP then also asserts `reg_wr`=1 and `link`=1; the datapath writes PC+4 into $31.
- `MCU_JAL_EN` not defined: 000011 is illegal and `link` is tied to 0.

## Structure
- Package `mcu_pkg` holds:
  - State enum (4-bit) and opcode constants.
  - ALUOp class encodings.
  - `alu_src_b` and `pc_src` encodings.
- Sub-module `mcu_out_decode`: purely combinational (state, latched opcode, `mem_ready`) → control outputs.
- The top level holds the state register, opcode latch, wait counter and sticky flags.

## Test plan
- Reset, then ADD (000000) with ready always high → states FETCH, DECODE, EXEC_R, WB_R; `reg_wr`=1 and `reg_dst`=1 only in cycle 4; back in FETCH in cycle 5.
- LW with 3 wait cycles on fetch and 2 on data → 10 cycles total; `mem_rd`/`iord` held through the waits; `reg_wr`=1 with `mem_to_reg`=1 in the final cycle.
- LUI (001111) → `sigext_high`=1 with ADD in EXEC_I and WB_I; `reg_dst`=0.
- Opcode 111111 → `illegal`=1 after DECODE and stays set; returns to FETCH with no `reg_wr`/`mem_wr`; reset clears it.
- `MEM_TIMEOUT`=4, `mem_ready` held low in MEM_WR → FAULT after 4 wait cycles, `fault`=1; a ready arriving in exactly the 4th wait cycle instead completes to FETCH.
- With `MCU_JAL_EN`, JAL → JUMP asserts `pc_wr`, `pc_src`=2, `reg_wr`, `link`. Without it, JAL sets `illegal`.
